// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table, off pattern, prescaler divide.
// Pure declarations, no latency; no flow control.
// Segment bit order throughout is bit0=a .. bit6=g, active-high before output polarity.
package seg7_pkg;

    localparam logic [6:0] HEX2SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_OFF = 7'h00;

    function automatic int calc_div(input int clk_hz, input int scan_hz);
        return clk_hz / scan_hz;
    endfunction

endpackage

// File: rtl/hex7_decoder.sv
// Hex nibble to active-high 7-segment pattern.
// Combinational, zero latency; no flow control.
// Table lives in seg7_pkg so every display consumer shares one glyph set.
module hex7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = HEX2SEG[nibble_i];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display driver with tear-free frame-boundary loading; SEG7_LZ_BLANK_EN enables leading-zero blanking.
// Pins registered: a digit appears on the clock edge of its scan tick, blank_i acts one cycle later.
// No backpressure: load_i is always accepted, pending_o shows a captured value still waiting for a frame boundary.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int CLK_HZ     = 50_000_000,
    parameter int SCAN_HZ    = 1000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [4*DIGITS-1:0]   value_i,
    input  logic [DIGITS-1:0]     dp_i,
    input  logic                  load_i,
    input  logic                  blank_i,
    output logic                  pending_o,
    output logic                  frame_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic [DIGITS-1:0]     an_o
);

    localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
    localparam int CW  = $clog2(DIV);
    localparam int IW  = $clog2(DIGITS);

    localparam logic [6:0]        SEG_IDLE = SEG_OFF ^ {7{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_IDLE  = {DIGITS{ACTIVE_LOW}};

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic                  tick;
    logic                  boundary;

    logic [4*DIGITS-1:0]   shadow_val;
    logic [DIGITS-1:0]     shadow_dp;
    logic [4*DIGITS-1:0]   disp_val;
    logic [DIGITS-1:0]     disp_dp;
    logic                  pending;

    // Per-digit snapshot taken at the tick that starts the digit, so a
    // frame-boundary display update never changes a digit mid-period.
    logic                  lit;
    logic [IW-1:0]         act_idx;
    logic [3:0]            held_nib;
    logic                  held_dp;
    logic                  held_lz;

    logic [3:0]            fresh_nib;
    logic                  fresh_dp;
    logic                  fresh_lz;
    logic [IW-1:0]         sel_idx;
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_lz;
    logic                  dark;
    logic [6:0]            seg_hi;
    logic [DIGITS-1:0]     an_hot;

    assign tick     = (cnt == CW'(DIV - 1));
    assign boundary = tick && (idx == IW'(DIGITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
            pending    <= 1'b0;
        end else begin
            if (boundary && load_i) begin
                disp_val <= value_i;
                disp_dp  <= dp_i;
                pending  <= 1'b0;
            end else if (boundary && pending) begin
                disp_val <= shadow_val;
                disp_dp  <= shadow_dp;
                pending  <= 1'b0;
            end else if (load_i) begin
                pending  <= 1'b1;
            end
            if (load_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
        end
    end

    always_comb begin
        fresh_nib = '0;
        fresh_dp  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                fresh_nib = disp_val[4*k +: 4];
                fresh_dp  = disp_dp[k];
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    logic lz_seen;

    // A digit stays dark while it and everything above it is zero without a dp.
    always_comb begin
        fresh_lz = 1'b0;
        lz_seen  = 1'b0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_seen = lz_seen | (|disp_val[4*k +: 4]) | disp_dp[k];
            if (idx == IW'(k))
                fresh_lz = ~lz_seen;
        end
    end
`else
    assign fresh_lz = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit      <= 1'b0;
            act_idx  <= '0;
            held_nib <= '0;
            held_dp  <= 1'b0;
            held_lz  <= 1'b0;
        end else if (tick) begin
            lit      <= 1'b1;
            act_idx  <= idx;
            held_nib <= fresh_nib;
            held_dp  <= fresh_dp;
            held_lz  <= fresh_lz;
        end
    end

    assign sel_idx = tick ? idx       : act_idx;
    assign sel_nib = tick ? fresh_nib : held_nib;
    assign sel_dp  = tick ? fresh_dp  : held_dp;
    assign sel_lz  = tick ? fresh_lz  : held_lz;
    assign dark    = !(lit || tick) || blank_i || sel_lz;

    hex7_decoder u_dec (
        .nibble_i (sel_nib),
        .seg_o    (seg_hi)
    );

    always_comb begin
        an_hot = '0;
        for (int k = 0; k < DIGITS; k++)
            an_hot[k] = (sel_idx == IW'(k));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_o   <= SEG_IDLE;
            dp_o    <= ACTIVE_LOW;
            an_o    <= AN_IDLE;
            frame_o <= 1'b0;
        end else begin
            seg_o   <= dark ? SEG_IDLE   : (seg_hi ^ {7{ACTIVE_LOW}});
            dp_o    <= dark ? ACTIVE_LOW : (sel_dp ^ ACTIVE_LOW);
            an_o    <= dark ? AN_IDLE    : (an_hot ^ {DIGITS{ACTIVE_LOW}});
            frame_o <= boundary;
        end
    end

    assign pending_o = pending;

endmodule
